// File: rtl/fma_cluster_pkg.sv
// Shared word and operand types for the fma_cluster FMA lanes and write buffer.
package fma_cluster_pkg;

    localparam int WORD_WIDTH  = 16;
    localparam int FIXED_POINT = 10;
    localparam int FMA_COUNT   = 2;

    typedef logic signed [WORD_WIDTH-1:0] word_t;

    // Field order matches the operand line: a in the top bits, c in the bottom.
    typedef struct packed {
        word_t a;
        word_t b;
        word_t c;
    } abc_t;

endpackage

// File: rtl/fma_lane.sv
// One fixed-point multiply-accumulate lane with a single register stage.
// FMA_CLUSTER_SATURATE_EN selects clamping of the sum instead of wrap-around.
module fma_lane
    import fma_cluster_pkg::*;
#(
    parameter int FRAC_BITS = FIXED_POINT
) (
    input  logic  clk_in,
    input  logic  rst_in,
    input  abc_t  abc_in,
    input  logic  valid_in,
    input  logic  use_new_c_in,
    input  logic  emit_in,
    output word_t acc_out,
    output logic  vld_out
);

    localparam int SW = 2*WORD_WIDTH + 1;

    logic signed [2*WORD_WIDTH-1:0] w_prod;
    logic signed [2*WORD_WIDTH-1:0] w_prod_sh;
    logic signed [SW-1:0]           w_sum;
    word_t                          w_addend;
    word_t                          w_next;
    word_t                          r_acc;
    logic                           r_vld;

`ifdef FMA_CLUSTER_SATURATE_EN
    function automatic word_t sat_word(input logic signed [SW-1:0] s);
        logic signed [SW-1:0] lim_hi;
        logic signed [SW-1:0] lim_lo;
        lim_hi = {{(SW-WORD_WIDTH+1){1'b0}}, {(WORD_WIDTH-1){1'b1}}};
        lim_lo = {{(SW-WORD_WIDTH+1){1'b1}}, {(WORD_WIDTH-1){1'b0}}};
        if (s > lim_hi)
            return {1'b0, {(WORD_WIDTH-1){1'b1}}};
        else if (s < lim_lo)
            return {1'b1, {(WORD_WIDTH-1){1'b0}}};
        else
            return s[WORD_WIDTH-1:0];
    endfunction
`endif

    // Arithmetic shift floors the scaled product toward negative infinity.
    assign w_prod    = $signed(abc_in.a) * $signed(abc_in.b);
    assign w_prod_sh = w_prod >>> FRAC_BITS;
    assign w_addend  = use_new_c_in ? abc_in.c : r_acc;
    assign w_sum     = {w_prod_sh[2*WORD_WIDTH-1], w_prod_sh}
                     + {{(WORD_WIDTH+1){w_addend[WORD_WIDTH-1]}}, w_addend};

`ifdef FMA_CLUSTER_SATURATE_EN
    assign w_next = sat_word(w_sum);
`else
    logic w_unused_hi;
    assign w_unused_hi = ^w_sum[SW-1:WORD_WIDTH];
    assign w_next      = w_sum[WORD_WIDTH-1:0];
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_acc <= '0;
            r_vld <= 1'b0;
        end else begin
            r_vld <= valid_in & emit_in;
            if (valid_in)
                r_acc <= w_next;
        end
    end

    assign acc_out = r_acc;
    assign vld_out = r_vld;

endmodule

// File: rtl/fma_cluster.sv
// FMA lane array plus a write buffer that packs three result rounds into one line.
// FMA_CLUSTER_SATURATE_EN (see fma_lane) clamps lane sums instead of wrapping.
module fma_cluster #(
    parameter int FMA_COUNT   = fma_cluster_pkg::FMA_COUNT,
    parameter int WORD_WIDTH  = fma_cluster_pkg::WORD_WIDTH,
    parameter int FIXED_POINT = fma_cluster_pkg::FIXED_POINT,
    parameter int LINE_WIDTH  = 3*WORD_WIDTH*FMA_COUNT
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic [3*WORD_WIDTH*FMA_COUNT-1:0] abc_in,
    input  logic                            abc_valid_in,
    input  logic                            use_new_c_in,
    input  logic                            output_can_be_valid_in,
    output logic [WORD_WIDTH*FMA_COUNT-1:0] fma_out,
    output logic [FMA_COUNT-1:0]            fma_valid_out,
    output logic [LINE_WIDTH-1:0]           line_out,
    output logic                            line_valid_out
);

    import fma_cluster_pkg::*;

    word_t                  w_acc [FMA_COUNT];
    logic [FMA_COUNT-1:0]   w_vld;
    logic                   w_cap;
    logic [1:0]             r_fill;
    logic [LINE_WIDTH-1:0]  r_line;
    logic                   r_line_vld;

    for (genvar i = 0; i < FMA_COUNT; i++) begin : g_lane
        abc_t w_abc;
        assign w_abc = abc_t'(abc_in[3*WORD_WIDTH*(FMA_COUNT-i)-1 -: 3*WORD_WIDTH]);

        fma_lane #(
            .FRAC_BITS (FIXED_POINT)
        ) u_lane (
            .clk_in       (clk_in),
            .rst_in       (rst_in),
            .abc_in       (w_abc),
            .valid_in     (abc_valid_in),
            .use_new_c_in (use_new_c_in),
            .emit_in      (output_can_be_valid_in),
            .acc_out      (w_acc[i]),
            .vld_out      (w_vld[i])
        );

        assign fma_out[WORD_WIDTH*(FMA_COUNT-i)-1 -: WORD_WIDTH] = w_acc[i];
    end

    assign fma_valid_out = w_vld;
    assign w_cap         = |w_vld;

    // Round k fills slots k*FMA_COUNT.. counted from the MSB; the pulse follows the third round.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_fill     <= 2'd0;
            r_line     <= '0;
            r_line_vld <= 1'b0;
        end else begin
            r_line_vld <= w_cap && (r_fill == 2'd2);
            if (w_cap) begin
                r_fill <= (r_fill == 2'd2) ? 2'd0 : r_fill + 2'd1;
                for (int k = 0; k < 3; k++) begin
                    if (r_fill == 2'(k)) begin
                        for (int i = 0; i < FMA_COUNT; i++)
                            r_line[LINE_WIDTH-1-(k*FMA_COUNT+i)*WORD_WIDTH -: WORD_WIDTH]
                                <= w_vld[i] ? w_acc[i] : '0;
                    end
                end
            end
        end
    end

    assign line_out       = r_line;
    assign line_valid_out = r_line_vld;

endmodule

// File: tb/tb_fma_cluster.sv
// Directed-vector bench for fma_cluster: lane arithmetic, async reset and line packing.
module tb_fma_cluster;

    logic        clk_in;
    logic        rst_in;
    logic [95:0] abc_in;
    logic        abc_valid_in;
    logic        use_new_c_in;
    logic        output_can_be_valid_in;
    logic [31:0] fma_out;
    logic [1:0]  fma_valid_out;
    logic [95:0] line_out;
    logic        line_valid_out;

    int n_checks = 0;
    int n_errors = 0;

`ifdef FMA_CLUSTER_SATURATE_EN
    localparam logic [15:0] EXP_OVF = 16'h7FFF;
`else
    localparam logic [15:0] EXP_OVF = 16'hFFC0;
`endif

    fma_cluster dut (
        .clk_in                 (clk_in),
        .rst_in                 (rst_in),
        .abc_in                 (abc_in),
        .abc_valid_in           (abc_valid_in),
        .use_new_c_in           (use_new_c_in),
        .output_can_be_valid_in (output_can_be_valid_in),
        .fma_out                (fma_out),
        .fma_valid_out          (fma_valid_out),
        .line_out               (line_out),
        .line_valid_out         (line_valid_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic [15:0] a0, input logic [15:0] b0, input logic [15:0] c0,
                         input logic [15:0] a1, input logic [15:0] b1, input logic [15:0] c1,
                         input logic vld, input logic newc, input logic emit);
        abc_in                 = {a0, b0, c0, a1, b1, c1};
        abc_valid_in           = vld;
        use_new_c_in           = newc;
        output_can_be_valid_in = emit;
    endtask

    task automatic round(input logic [15:0] r0, input logic [15:0] r1, input logic emit);
        drive(16'h0, 16'h0, r0, 16'h0, 16'h0, r1, 1'b1, 1'b1, emit);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_in = 1'b1;
        drive(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        rst_in = 1'b0;
        check("rst_fma_out",    fma_out,        32'h0);
        check("rst_fma_valid",  fma_valid_out,  2'b00);
        check("rst_line_out",   line_out,       96'h0);
        check("rst_line_valid", line_valid_out, 1'b0);

        // lane0 2.0*1.5+0.25, lane1 1.0*2.0+c
        drive(16'h0800, 16'h0600, 16'h0100, 16'h0400, 16'h0800, 16'h0010, 1'b1, 1'b1, 1'b1);
        step();
        check("newc_fma_out",   fma_out,       {16'h0D00, 16'h0810});
        check("newc_valid",     fma_valid_out, 2'b11);
        check("newc_line_vld",  line_valid_out, 1'b0);

        drive(16'h0400, 16'h0400, 16'h7777, 16'hFC00, 16'h0400, 16'h1234, 1'b1, 1'b0, 1'b1);
        step();
        check("acc_fma_out",    fma_out,       {16'h1100, 16'h0410});

        drive(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 1'b0, 1'b1, 1'b1);
        step();
        check("idle_hold",      fma_out,       {16'h1100, 16'h0410});
        check("idle_valid",     fma_valid_out, 2'b00);

        // Two rounds captured; an async reset now must clear everything before any edge.
        #3;
        rst_in = 1'b1;
        #1;
        check("async_fma_out",  fma_out,        32'h0);
        check("async_line_out", line_out,       96'h0);
        check("async_valid",    fma_valid_out,  2'b00);
        step();
        rst_in = 1'b0;

        drive(16'hFC00, 16'h0200, 16'h0000, 16'h7FFF, 16'h7FFF, 16'h0000, 1'b1, 1'b1, 1'b1);
        step();
        check("neg_ovf_out",    fma_out,       {16'hFE00, EXP_OVF});
        drive(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        step();
        check("partial_discard", line_valid_out, 1'b0);

        rst_in = 1'b1;
        step();
        rst_in = 1'b0;

        round(16'h1, 16'h2, 1'b1);
        round(16'h9, 16'h9, 1'b0);
        check("nocap_valid",    fma_valid_out, 2'b00);
        round(16'h3, 16'h4, 1'b1);
        round(16'h5, 16'h6, 1'b1);
        check("r3_fma_out",     fma_out,        {16'h5, 16'h6});
        check("r3_no_pulse",    line_valid_out, 1'b0);
        round(16'h7, 16'h8, 1'b1);
        check("line1_pulse",    line_valid_out, 1'b1);
        check("line1_data",     line_out,       96'h0001_0002_0003_0004_0005_0006);
        drive(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        step();
        check("pulse_one_cyc",  line_valid_out, 1'b0);
        check("slot0_overwr",   line_out,       96'h0007_0008_0003_0004_0005_0006);
        step();
        check("line_hold",      line_out,       96'h0007_0008_0003_0004_0005_0006);
        round(16'h9, 16'hA, 1'b1);
        round(16'hB, 16'hC, 1'b1);
        drive(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        step();
        check("line2_pulse",    line_valid_out, 1'b1);
        check("line2_data",     line_out,       96'h0007_0008_0009_000A_000B_000C);
        step();
        check("line2_end",      line_valid_out, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
